// File: rtl/map_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// map_port_arbiter_pkg : pixel classes, map extents and read-tag layout
// Revision: 1.0
// ---------------------------------------------------------------------------
package map_port_arbiter_pkg;

    localparam logic [7:0] c_pix_wall = 8'h26;
    localparam logic [7:0] c_pix_hole = 8'h49;
    localparam logic [7:0] c_pix_win  = 8'hF9;

    localparam int c_map_cols = 640;
    localparam int c_map_rows = 480;
    localparam int c_addr_w   = 10;
    localparam int c_tag_id_w = 2;

    typedef struct packed {
        logic                  valid;
        logic [c_tag_id_w-1:0] id;
        logic                  oob;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/map_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// map_port_arbiter_if : requester-side and map-port-A signals of the arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface map_port_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic                    enable;
    logic [NUM_REQ-1:0]      req;
    logic [10*NUM_REQ-1:0]   req_col;
    logic [10*NUM_REQ-1:0]   req_row;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      rvalid;
    logic [7:0]              rdata;
    logic [9:0]              map_col_addr;
    logic [9:0]              map_row_addr;
    logic [7:0]              map_data;
    logic                    busy;

    modport slave (
        input  enable, req, req_col, req_row, map_data,
        output gnt, rvalid, rdata, map_col_addr, map_row_addr, busy
    );

    modport master (
        output enable, req, req_col, req_row, map_data,
        input  gnt, rvalid, rdata, map_col_addr, map_row_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/map_port_arbiter_rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// map_port_arbiter_rr_picker : first eligible index at/after pointer, with wrap
// Revision: 1.0
// ---------------------------------------------------------------------------
module map_port_arbiter_rr_picker
    import map_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]    i_eligible,
    input  logic [c_tag_id_w-1:0] i_pointer,
    output logic [NUM_REQ-1:0]    o_winner,
    output logic [c_tag_id_w-1:0] o_winner_idx,
    output logic                  o_any
);
    int w_cand;

    always_comb begin
        o_winner     = '0;
        o_winner_idx = '0;
        o_any        = 1'b0;
        w_cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = (int'(i_pointer) + k) % NUM_REQ;
            if (!o_any && i_eligible[w_cand]) begin
                o_any            = 1'b1;
                o_winner_idx     = c_tag_id_w'(w_cand);
                o_winner[w_cand] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/map_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// map_port_arbiter : round-robin sharing of map read port A, with tagged
//                    return routing and out-of-range substitution.
// Revision: 1.0
// ---------------------------------------------------------------------------
module map_port_arbiter
    import map_port_arbiter_pkg::*;
#(
    parameter int         NUM_REQ      = 3,
    parameter int         READ_LATENCY = 2,
    parameter int         MAP_COLS     = c_map_cols,
    parameter int         MAP_ROWS     = c_map_rows,
    parameter logic [7:0] OOB_VALUE    = c_pix_wall
) (
    input  logic              clk,
    input  logic              rst_n,
    map_port_arbiter_if.slave bus
);
    localparam logic [c_tag_id_w-1:0] c_last_idx = c_tag_id_w'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    w_eligible;
    logic [NUM_REQ-1:0]    w_winner;
    logic [NUM_REQ-1:0]    w_rvalid;
    logic [c_tag_id_w-1:0] r_ptr;
    logic [c_tag_id_w-1:0] w_idx;
    logic                  w_any;
    logic [c_addr_w-1:0]   r_col_addr;
    logic [c_addr_w-1:0]   r_row_addr;
    logic [c_addr_w-1:0]   w_col;
    logic [c_addr_w-1:0]   w_row;
    logic                  w_oob;
    logic                  w_busy;
    tag_t                  w_tag_out;

    // Index 0 is loaded together with gnt (the cycle the map sees the address);
    // index READ_LATENCY lines up with map_data.
    tag_t r_tag [0:READ_LATENCY];

    // Masking the current grant gives the requester one cycle to drop req.
    assign w_eligible = bus.req & ~r_gnt;

    map_port_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_eligible   (w_eligible),
        .i_pointer    (r_ptr),
        .o_winner     (w_winner),
        .o_winner_idx (w_idx),
        .o_any        (w_any)
    );

    assign w_col = bus.req_col[c_addr_w*int'(w_idx) +: c_addr_w];
    assign w_row = bus.req_row[c_addr_w*int'(w_idx) +: c_addr_w];
    assign w_oob = (int'(w_col) >= MAP_COLS) || (int'(w_row) >= MAP_ROWS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= '0;
            r_ptr      <= '0;
            r_col_addr <= '0;
            r_row_addr <= '0;
            for (int s = 0; s <= READ_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            if (bus.enable && w_any) begin
                r_gnt      <= w_winner;
                r_col_addr <= w_col;
                r_row_addr <= w_row;
                r_ptr      <= (w_idx == c_last_idx) ? '0 : w_idx + 1'b1;
                r_tag[0]   <= '{valid: 1'b1, id: w_idx, oob: w_oob};
            end else begin
                r_gnt    <= '0;
                r_tag[0] <= '0;
            end
            for (int s = 1; s <= READ_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_tag_out = r_tag[READ_LATENCY];

    always_comb begin
        w_rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rvalid[i] = w_tag_out.valid && (w_tag_out.id == c_tag_id_w'(i));
        end
    end

    always_comb begin
        w_busy = |r_gnt;
        for (int s = 0; s <= READ_LATENCY; s++) begin
            w_busy = w_busy | r_tag[s].valid;
        end
    end

    assign bus.gnt          = r_gnt;
    assign bus.rvalid       = w_rvalid;
    assign bus.rdata        = !w_tag_out.valid ? 8'h00 :
                              (w_tag_out.oob ? OOB_VALUE : bus.map_data);
    assign bus.map_col_addr = r_col_addr;
    assign bus.map_row_addr = r_row_addr;
    assign bus.busy         = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_map_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_map_port_arbiter : directed self-checking bench for map_port_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_map_port_arbiter;
    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    localparam logic [9:0] COL_TAB [0:2] = '{10'h105, 10'h12A, 10'h233};
    localparam logic [9:0] ROW_TAB [0:2] = '{10'h040, 10'h071, 10'h1C3};
    // Expected pixel for each table address: low byte of col XOR low byte of row.
    localparam logic [7:0] PIX_TAB [0:2] = '{8'h45, 8'h5B, 8'hF0};

    map_port_arbiter_if #(.NUM_REQ(3)) bus  ();
    map_port_arbiter_if #(.NUM_REQ(3)) bus4 ();

    map_port_arbiter #(.NUM_REQ(3), .READ_LATENCY(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    map_port_arbiter #(.NUM_REQ(3), .READ_LATENCY(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Map contents: a HOLE at (0x20F,0xFE), zero off-map, otherwise col^row.
    function automatic logic [7:0] map_pix(input logic [9:0] col, input logic [9:0] row);
        if (col == 10'h20F && row == 10'h0FE) return 8'h49;
        if (int'(col) >= 640 || int'(row) >= 480) return 8'h00;
        return col[7:0] ^ row[7:0];
    endfunction

    logic [7:0] m2 [0:1];
    logic [7:0] m4 [0:3];
    always @(posedge clk) begin
        m2[0] <= map_pix(bus.map_col_addr, bus.map_row_addr);
        m2[1] <= m2[0];
        m4[0] <= map_pix(bus4.map_col_addr, bus4.map_row_addr);
        for (int s = 1; s < 4; s++) m4[s] <= m4[s-1];
    end
    assign bus.map_data  = m2[1];
    assign bus4.map_data = m4[3];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [9:0] col, input logic [9:0] row);
        bus.req_col[10*i +: 10] = col;
        bus.req_row[10*i +: 10] = row;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.req = 3'b111;
        for (int i = 0; i < 3; i++) set_addr(i, COL_TAB[i], ROW_TAB[i]);
        bus4.enable = 1'b1;
        bus4.req = 3'b000;
        bus4.req_col = '0;
        bus4.req_row = '0;
        repeat (3) tick();
        vec_cnt++; if (bus.gnt !== 3'b000) begin err_cnt++; $display("FAIL reset gnt: got %b want 000", bus.gnt); end
        vec_cnt++; if (bus.rvalid !== 3'b000) begin err_cnt++; $display("FAIL reset rvalid: got %b want 000", bus.rvalid); end
        vec_cnt++; if (bus.rdata !== 8'h00) begin err_cnt++; $display("FAIL reset rdata: got %h want 00", bus.rdata); end
        vec_cnt++; if (bus.map_col_addr !== 10'h000 || bus.map_row_addr !== 10'h000) begin
            err_cnt++; $display("FAIL reset addr: got %h/%h want 000/000", bus.map_col_addr, bus.map_row_addr); end
        vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        bus.req = 3'b000;
        tick();
        vec_cnt++; if (bus.gnt !== 3'b000) begin err_cnt++; $display("FAIL reset idle gnt: got %b want 000", bus.gnt); end
    endtask

    task automatic test_rotation;
        logic [2:0] eg, ev;
        logic [7:0] ed;
        bus.req = 3'b111;
        for (int k = 1; k <= 11; k++) begin
            tick();
            eg = (k <= 9) ? 3'(1 << ((k - 1) % 3)) : 3'b000;
            ev = (k >= 3) ? 3'(1 << ((k - 3) % 3)) : 3'b000;
            ed = (k >= 3) ? PIX_TAB[(k - 3) % 3] : 8'h00;
            vec_cnt++; if (bus.gnt !== eg) begin err_cnt++; $display("FAIL rotation gnt c%0d: got %b want %b", k, bus.gnt, eg); end
            vec_cnt++; if (bus.rvalid !== ev) begin err_cnt++; $display("FAIL rotation rvalid c%0d: got %b want %b", k, bus.rvalid, ev); end
            vec_cnt++; if (bus.rdata !== ed) begin err_cnt++; $display("FAIL rotation rdata c%0d: got %h want %h", k, bus.rdata, ed); end
            if (k <= 9) begin
                vec_cnt++; if (bus.map_col_addr !== COL_TAB[(k - 1) % 3]) begin
                    err_cnt++; $display("FAIL rotation col c%0d: got %h want %h", k, bus.map_col_addr, COL_TAB[(k - 1) % 3]); end
            end
            if (k == 9) bus.req = 3'b000;
        end
    endtask

    task automatic test_single;
        set_addr(0, 10'h20F, 10'h0FE);
        bus.req = 3'b001;
        tick();
        vec_cnt++; if (bus.gnt !== 3'b001) begin err_cnt++; $display("FAIL single gnt: got %b want 001", bus.gnt); end
        vec_cnt++; if (bus.map_col_addr !== 10'h20F || bus.map_row_addr !== 10'h0FE) begin
            err_cnt++; $display("FAIL single addr: got %h/%h want 20f/0fe", bus.map_col_addr, bus.map_row_addr); end
        vec_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL single busy: got %b want 1", bus.busy); end
        bus.req = 3'b000;
        tick();
        vec_cnt++; if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b000) begin
            err_cnt++; $display("FAIL single c2: got gnt %b rvalid %b want 000/000", bus.gnt, bus.rvalid); end
        tick();
        vec_cnt++; if (bus.rvalid !== 3'b001) begin err_cnt++; $display("FAIL single rvalid: got %b want 001", bus.rvalid); end
        vec_cnt++; if (bus.rdata !== 8'h49) begin err_cnt++; $display("FAIL single rdata: got %h want 49", bus.rdata); end
        tick();
        vec_cnt++; if (bus.rvalid !== 3'b000 || bus.rdata !== 8'h00 || bus.busy !== 1'b0) begin
            err_cnt++; $display("FAIL single drain: got rvalid %b rdata %h busy %b want 000/00/0", bus.rvalid, bus.rdata, bus.busy); end
        set_addr(0, COL_TAB[0], ROW_TAB[0]);
    endtask

    task automatic test_back_to_back;
        localparam logic [2:0] EG [1:5] = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b000};
        localparam logic [2:0] EV [1:5] = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b010};
        bus.req = 3'b010;
        for (int k = 1; k <= 5; k++) begin
            tick();
            vec_cnt++; if (bus.gnt !== EG[k]) begin err_cnt++; $display("FAIL b2b gnt c%0d: got %b want %b", k, bus.gnt, EG[k]); end
            vec_cnt++; if (bus.rvalid !== EV[k]) begin err_cnt++; $display("FAIL b2b rvalid c%0d: got %b want %b", k, bus.rvalid, EV[k]); end
            if (EV[k] != 3'b000) begin
                vec_cnt++; if (bus.rdata !== 8'h5B) begin err_cnt++; $display("FAIL b2b rdata c%0d: got %h want 5b", k, bus.rdata); end
            end
            if (k == 3) bus.req = 3'b000;
        end
    endtask

    task automatic test_oob;
        localparam logic [9:0] OC [0:2] = '{10'd640, 10'd0, 10'd639};
        localparam logic [9:0] OR [0:2] = '{10'd10, 10'd480, 10'd479};
        localparam logic [7:0] OD [0:2] = '{8'h26, 8'h26, 8'hA0};
        for (int t = 0; t < 3; t++) begin
            set_addr(2, OC[t], OR[t]);
            bus.req = 3'b100;
            tick();
            vec_cnt++; if (bus.gnt !== 3'b100 || bus.map_col_addr !== OC[t] || bus.map_row_addr !== OR[t]) begin
                err_cnt++; $display("FAIL oob grant %0d: got gnt %b addr %0d/%0d want 100 %0d/%0d",
                                    t, bus.gnt, bus.map_col_addr, bus.map_row_addr, OC[t], OR[t]); end
            bus.req = 3'b000;
            tick();
            tick();
            vec_cnt++; if (bus.rvalid !== 3'b100) begin err_cnt++; $display("FAIL oob rvalid %0d: got %b want 100", t, bus.rvalid); end
            vec_cnt++; if (bus.rdata !== OD[t]) begin err_cnt++; $display("FAIL oob rdata %0d: got %h want %h", t, bus.rdata, OD[t]); end
            tick();
        end
        set_addr(2, COL_TAB[2], ROW_TAB[2]);
    endtask

    task automatic test_reset_mid;
        bus.req = 3'b011;
        tick();
        vec_cnt++; if (bus.gnt !== 3'b001) begin err_cnt++; $display("FAIL rstmid g1: got %b want 001", bus.gnt); end
        tick();
        vec_cnt++; if (bus.gnt !== 3'b010) begin err_cnt++; $display("FAIL rstmid g2: got %b want 010", bus.gnt); end
        tick();
        vec_cnt++; if (bus.gnt !== 3'b001) begin err_cnt++; $display("FAIL rstmid g3: got %b want 001", bus.gnt); end
        bus.req = 3'b000;
        #1 rst_n = 1'b0;
        #1;
        vec_cnt++; if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b000 || bus.rdata !== 8'h00 || bus.busy !== 1'b0) begin
            err_cnt++; $display("FAIL rstmid outputs: got gnt %b rvalid %b rdata %h busy %b want all 0",
                                bus.gnt, bus.rvalid, bus.rdata, bus.busy); end
        vec_cnt++; if (bus.map_col_addr !== 10'h000 || bus.map_row_addr !== 10'h000) begin
            err_cnt++; $display("FAIL rstmid addr: got %h/%h want 000/000", bus.map_col_addr, bus.map_row_addr); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vec_cnt++; if (bus.rvalid !== 3'b000 || bus.busy !== 1'b0) begin
                err_cnt++; $display("FAIL rstmid drain %0d: got rvalid %b busy %b want 000/0", k, bus.rvalid, bus.busy); end
        end
        bus.req = 3'b101;
        tick();
        vec_cnt++; if (bus.gnt !== 3'b001) begin err_cnt++; $display("FAIL rstmid first gnt: got %b want 001", bus.gnt); end
        bus.req = 3'b000;
        tick();
        tick();
        vec_cnt++; if (bus.rvalid !== 3'b001 || bus.rdata !== 8'h45) begin
            err_cnt++; $display("FAIL rstmid rvalid: got %b/%h want 001/45", bus.rvalid, bus.rdata); end
        tick();
    endtask

    task automatic test_enable;
        bus.enable = 1'b0;
        bus.req = 3'b111;
        for (int k = 1; k <= 5; k++) begin
            tick();
            vec_cnt++; if (bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin
                err_cnt++; $display("FAIL enable off c%0d: got gnt %b busy %b want 000/0", k, bus.gnt, bus.busy); end
        end
        bus.enable = 1'b1;
        tick();
        vec_cnt++; if (bus.gnt !== 3'b010) begin err_cnt++; $display("FAIL enable resume: got %b want 010", bus.gnt); end
        tick();
        vec_cnt++; if (bus.gnt !== 3'b100) begin err_cnt++; $display("FAIL enable second: got %b want 100", bus.gnt); end
        bus.enable = 1'b0;
        tick();
        vec_cnt++; if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b010 || bus.rdata !== 8'h5B) begin
            err_cnt++; $display("FAIL enable drain1: got gnt %b rvalid %b rdata %h want 000/010/5b", bus.gnt, bus.rvalid, bus.rdata); end
        tick();
        vec_cnt++; if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b100 || bus.rdata !== 8'hF0) begin
            err_cnt++; $display("FAIL enable drain2: got gnt %b rvalid %b rdata %h want 000/100/f0", bus.gnt, bus.rvalid, bus.rdata); end
        tick();
        bus.enable = 1'b1;
        tick();
        vec_cnt++; if (bus.gnt !== 3'b001) begin err_cnt++; $display("FAIL enable wrap: got %b want 001", bus.gnt); end
        bus.req = 3'b000;
        tick();
        tick();
        vec_cnt++; if (bus.rvalid !== 3'b001 || bus.rdata !== 8'h45) begin
            err_cnt++; $display("FAIL enable last rvalid: got %b/%h want 001/45", bus.rvalid, bus.rdata); end
        tick();
    endtask

    task automatic test_latency4;
        bus4.req_col[9:0] = 10'h20F;
        bus4.req_row[9:0] = 10'h0FE;
        bus4.req = 3'b001;
        tick();
        vec_cnt++; if (bus4.gnt !== 3'b001) begin err_cnt++; $display("FAIL lat4 gnt: got %b want 001", bus4.gnt); end
        bus4.req = 3'b000;
        for (int k = 2; k <= 4; k++) begin
            tick();
            vec_cnt++; if (bus4.rvalid !== 3'b000 || bus4.busy !== 1'b1) begin
                err_cnt++; $display("FAIL lat4 wait c%0d: got rvalid %b busy %b want 000/1", k, bus4.rvalid, bus4.busy); end
        end
        tick();
        vec_cnt++; if (bus4.rvalid !== 3'b001 || bus4.rdata !== 8'h49) begin
            err_cnt++; $display("FAIL lat4 rvalid: got %b/%h want 001/49", bus4.rvalid, bus4.rdata); end
        tick();
        vec_cnt++; if (bus4.rvalid !== 3'b000 || bus4.busy !== 1'b0) begin
            err_cnt++; $display("FAIL lat4 idle: got rvalid %b busy %b want 000/0", bus4.rvalid, bus4.busy); end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_rotation();
        test_single();
        test_back_to_back();
        test_oob();
        test_reset_mid();
        test_enable();
        test_latency4();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/map_port_arbiter.md
Name: map_port_arbiter

Overview:
- Round-robin arbiter sharing the map's single collision read port (port A: col/row address in, 8-bit pixel class out) among up to 4 requesters: ball collision scanner, future enemy/hazard scanners, debug probe.
- Issues one map read per cycle, tracks the fixed map read latency with a tag pipeline, and routes each returned pixel back to its requester with a valid strobe.
- Sits between the requester blocks and the map instance; the video port B is untouched.

Parameters:
- NUM_REQ, 3, number of requesters (1..4).
- READ_LATENCY, 2, clock edges from map address presentation to map_data valid (1..4).
- MAP_COLS, 640, legal column range is 0..MAP_COLS-1.
- MAP_ROWS, 480, legal row range is 0..MAP_ROWS-1.
- OOB_VALUE, 8'h26, pixel class returned for out-of-range addresses (the WALL class).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = new grants allowed; 0 = no new grants, in-flight reads still complete.
- req  in  NUM_REQ  per-requester read request, level.
- req_col  in  10*NUM_REQ  column address; requester i uses bits [10i+9:10i].
- req_row  in  10*NUM_REQ  row address; same packing as req_col.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse; the request is accepted this cycle.
- rvalid  out  NUM_REQ  one-hot, one-cycle pulse; rdata belongs to requester i.
- rdata  out  8  returned pixel class, shared by all requesters.
- map_col_addr  out  10  to map port A.
- map_row_addr  out  10  to map port A.
- map_data  in  8  from map port A.
- busy  out  1  1 while any read is in flight.

Behaviour:
- Reset asserted (async): gnt=0, rvalid=0, rdata=0, map_col_addr=0, map_row_addr=0, busy=0, RR pointer=0, tag pipeline cleared.
- Arbitration, evaluated every clock edge:
  - Eligible set = req & ~gnt. A requester granted in the current cycle is masked for one cycle so it can drop req.
  - Winner = first eligible index at or after the pointer, searching upward with wrap.
  - At the edge: gnt[winner]<=1; map_col_addr/map_row_addr <= winner's address; pointer <= winner+1, wrapping to 0 at NUM_REQ.
  - No eligible requester, or enable=0: gnt<=0; address outputs hold their last value; pointer holds.
- A requester holds req and its address stable until it sees gnt. Keeping req high after gnt is a new request.
- Throughput: one grant per cycle in aggregate; at most one grant every 2 cycles for any single requester.
- Out-of-range check is done at grant time: col>=MAP_COLS or row>=MAP_ROWS sets the tag's oob bit. The address is still driven to the map unchanged.
- Tag pipeline: READ_LATENCY stages of {valid, id[1:0], oob}, entered at the grant edge.
  - Stage output valid: rvalid[id]=1 combinationally, in cycle (gnt cycle + READ_LATENCY).
  - rdata = oob ? OOB_VALUE : map_data when valid, else 0.
- busy = OR of all tag valid bits, or any gnt high.
- Simultaneous requests: all requesters asserting continuously are served in strict rotation, e.g. 0,1,2,0,1,2. Starvation bound is NUM_REQ-1 grants.
- enable dropped mid-stream: grants stop at the next edge; outstanding tags still drain and produce rvalid.
- Reset mid-operation: outstanding reads are discarded and no rvalid is produced. After release, the first grant goes to the lowest eligible index.
- NUM_REQ=1: the pointer is a constant 0 and the masking rule still applies.

Decomposition:
- Shared package/header holds:
  - pixel-class constants WALL=8'h26, HOLE=8'h49, WIN=8'hF9 (also used by the ball and map blocks);
  - MAP_COLS/MAP_ROWS defaults;
  - tag field widths.
- One natural sub-module: rr_picker (combinational; inputs eligible mask and pointer, outputs one-hot winner and index).
- The tag shift register stays inline.

Test Plan:
- Single requester 0, addr (col 0x20F, row 0xFE); map model returns 8'h49 -> gnt[0] pulses 1 cycle; map addr = 0x20F/0xFE; rvalid[0] with rdata=8'h49 exactly 2 cycles after gnt.
- Requesters 0,1,2 held high for 9 cycles -> grant order 0,1,2,0,1,2,0,1,2; every grant paired with one matching rvalid 2 cycles later.
- Requester 1 keeps req high for 4 cycles, others idle -> gnt[1] in cycles 1 and 3 only, never in back-to-back cycles.
- Requester 2 addr col=640, row=10, map_data=8'h00 -> rvalid[2] with rdata=8'h26. Then row=480, col=0 -> rdata=8'h26 again.
- Three grants issued, reset pulsed low one cycle after the last grant -> no rvalid from any of them; all outputs 0; busy=0.
- enable=0 for 5 cycles while req=3'b111 -> no gnt; enable=1 -> grants resume from the held pointer value; READ_LATENCY=4 rerun gives a 4-cycle gnt-to-rvalid gap.
